// File: rtl/aq_reduce_pkg.sv
// aq_reduce_pkg: shared state encoding and default width for the reduce line controller.
package aq_reduce_pkg;
    localparam int AQ_SIZE_W = 16;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_t;
endpackage

// File: rtl/aq_reduce_line_ctrl_if.sv
// aq_reduce_line_ctrl_if: pixel stream and calculator strobe bundle for the line controller.
interface aq_reduce_line_ctrl_if;
    logic S_VALID;
    logic S_READY;
    logic S_LAST;
    logic M_READY;
    logic CALC_START;
    logic CALC_ENA;
    logic CALC_VALID;
    logic OUT_STROBE;
    modport slave (
        input  S_VALID, S_LAST, M_READY, CALC_VALID,
        output S_READY, CALC_START, CALC_ENA, OUT_STROBE
    );
    modport master (
        output S_VALID, S_LAST, M_READY, CALC_VALID,
        input  S_READY, CALC_START, CALC_ENA, OUT_STROBE
    );
endinterface

// File: rtl/aq_sat_counter.sv
// aq_sat_counter: up-counter with synchronous clear that holds at all-ones instead of wrapping.
module aq_sat_counter import aq_reduce_pkg::*; #(
    parameter int W = AQ_SIZE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk) begin
        if (rst || i_clr) r_count <= '0;
        else if (i_inc && r_count != '1) r_count <= r_count + W'(1);
    end
    assign o_count = r_count;
endmodule

// File: rtl/aq_reduce_line_ctrl.sv
// aq_reduce_line_ctrl: per-line sequencer feeding the size/weight calculator one ENA per accepted pixel
// and counting the output pixels it reports back.
module aq_reduce_line_ctrl import aq_reduce_pkg::*; #(
    parameter int W = AQ_SIZE_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LINE_START,
    input  logic [W-1:0]  ORG,
    input  logic [W-1:0]  CNV,
    output logic          BUSY,
    output logic          LINE_DONE,
    output logic          CFG_ERR,
    output logic          LEN_ERR,
    output logic [W-1:0]  IN_COUNT,
    output logic [W-1:0]  OUT_COUNT,
    aq_reduce_line_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_RUN   = RUN;
    localparam logic [2:0] ST_DRAIN = DRAIN;
    localparam logic [2:0] ST_FLUSH = FLUSH;
    localparam logic [2:0] ST_DONE  = DONE;

    logic [2:0]   r_state;
    logic [2:0]   w_next;
    logic [W-1:0] r_org;
    logic         r_ena_d1;
    logic         r_cfg_err;
    logic         r_len_err;
    logic         w_cfg_bad;
    logic         w_start_ok;
    logic         w_acc;
    logic         w_at_end;
    logic         w_len_set;

    assign w_cfg_bad  = ORG == '0 || CNV == '0 || CNV > ORG;
    assign w_start_ok = r_state == ST_IDLE && LINE_START && !w_cfg_bad;
    assign w_at_end   = IN_COUNT == r_org - W'(1);

    assign bus.S_READY    = r_state == ST_RUN ? bus.M_READY : r_state == ST_DRAIN;
    assign w_acc          = bus.S_VALID && bus.S_READY;
    assign bus.CALC_ENA   = r_state == ST_RUN && w_acc;
    assign bus.CALC_START = bus.CALC_ENA && IN_COUNT == '0;
    // calculator answers one cycle after each ENA, so its VALID is qualified by the delayed strobe
    assign bus.OUT_STROBE = r_ena_d1 && bus.CALC_VALID;

    assign BUSY      = r_state != ST_IDLE;
    assign LINE_DONE = r_state == ST_DONE;
    assign CFG_ERR   = r_cfg_err;
    assign LEN_ERR   = r_len_err;

    always_comb begin
        w_next    = r_state;
        w_len_set = 1'b0;
        case (r_state)
            ST_IDLE:  w_next = w_start_ok ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (w_acc && (bus.S_LAST || w_at_end)) begin
                    w_next    = bus.S_LAST ? ST_FLUSH : ST_DRAIN;
                    w_len_set = !(bus.S_LAST && w_at_end);
                end
            end
            ST_DRAIN: w_next = w_acc && bus.S_LAST ? ST_FLUSH : ST_DRAIN;
            ST_FLUSH: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_org     <= '0;
            r_ena_d1  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ena_d1  <= bus.CALC_ENA;
            r_cfg_err <= r_state == ST_IDLE && LINE_START && w_cfg_bad;
            r_len_err <= w_start_ok ? 1'b0 : r_len_err | w_len_set;
            if (w_start_ok) r_org <= ORG;
        end
    end

    aq_sat_counter #(.W(W)) u_in_cnt (
        .clk     (CLK),
        .rst     (RST),
        .i_clr   (w_start_ok),
        .i_inc   (bus.CALC_ENA),
        .o_count (IN_COUNT)
    );

    aq_sat_counter #(.W(W)) u_out_cnt (
        .clk     (CLK),
        .rst     (RST),
        .i_clr   (w_start_ok),
        .i_inc   (bus.OUT_STROBE),
        .o_count (OUT_COUNT)
    );
endmodule

// File: tb/tb_aq_reduce_line_ctrl.sv
// tb_aq_reduce_line_ctrl: scoreboard bench for the reduce line controller.
module tb_aq_reduce_line_ctrl;
    localparam int W = 16;

    typedef struct {
        int in_c;
        int out_c;
        int len;
    } line_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         LINE_START = 1'b0;
    logic [W-1:0] ORG = '0;
    logic [W-1:0] CNV = '0;
    logic         BUSY, LINE_DONE, CFG_ERR, LEN_ERR;
    logic [W-1:0] IN_COUNT, OUT_COUNT;

    aq_reduce_line_ctrl_if b();

    aq_reduce_line_ctrl #(.W(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LINE_START (LINE_START),
        .ORG        (ORG),
        .CNV        (CNV),
        .BUSY       (BUSY),
        .LINE_DONE  (LINE_DONE),
        .CFG_ERR    (CFG_ERR),
        .LEN_ERR    (LEN_ERR),
        .IN_COUNT   (IN_COUNT),
        .OUT_COUNT  (OUT_COUNT),
        .bus        (b)
    );

    always #5 CLK = ~CLK;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    done_cyc = 0;
    int    n_ena = 0;
    int    n_done = 0;
    int    n_cfg = 0;
    bit    q_start[$];
    line_t q_line[$];

    // sample at the falling edge, pop scoreboards, then advance to just past the rising edge
    task automatic cycle();
        bit    es;
        line_t e;
        @(negedge CLK);
        if (b.S_VALID && b.S_READY) acc_cyc = cyc;
        if (CFG_ERR) n_cfg++;
        checks++;
        if (b.CALC_START && !b.CALC_ENA) begin
            errors++;
            $display("FAIL start_without_ena: CALC_START=%0b CALC_ENA=%0b at cycle %0d", b.CALC_START, b.CALC_ENA, cyc);
        end
        if (b.CALC_ENA) begin
            n_ena++;
            checks++;
            if (q_start.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ena: CALC_ENA=1 with no pixel expected at cycle %0d", cyc);
            end else begin
                es = q_start.pop_front();
                if (b.CALC_START !== es) begin
                    errors++;
                    $display("FAIL calc_start: got %0b expected %0b at cycle %0d", b.CALC_START, es, cyc);
                end
            end
        end
        if (LINE_DONE) begin
            n_done++;
            done_cyc = cyc;
            checks++;
            if (q_line.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: LINE_DONE=1 with no line expected at cycle %0d", cyc);
            end else begin
                e = q_line.pop_front();
                checks += 2;
                if (IN_COUNT !== W'(e.in_c)) begin
                    errors++;
                    $display("FAIL in_count: got %0d expected %0d", IN_COUNT, e.in_c);
                end
                if (LEN_ERR !== e.len[0]) begin
                    errors++;
                    $display("FAIL len_err: got %0b expected %0d", LEN_ERR, e.len);
                end
                if (e.out_c >= 0) begin
                    checks++;
                    if (OUT_COUNT !== W'(e.out_c)) begin
                        errors++;
                        $display("FAIL out_count: got %0d expected %0d", OUT_COUNT, e.out_c);
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic start_line(input int org, input int cnv);
        LINE_START = 1'b1;
        ORG = W'(org);
        CNV = W'(cnv);
        cycle();
        LINE_START = 1'b0;
    endtask

    task automatic send_line(input int org, input int cnv, input int npix, input int st_lo,
                             input int st_hi, input int cv_on, input bit chk_out);
        int    idx = 0;
        int    lc = 0;
        int    w = 0;
        int    d0, e0, exp_in;
        line_t e;
        e0 = n_ena;
        start_line(org, cnv);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %0b expected 1", BUSY);
        end
        exp_in  = npix < org ? npix : org;
        e.in_c  = exp_in;
        e.out_c = chk_out ? (cv_on > 0 ? exp_in - 1 : exp_in) : -1;
        e.len   = npix != org ? 1 : 0;
        q_line.push_back(e);
        while (idx < npix) begin
            b.S_VALID    = 1'b1;
            b.S_LAST     = idx == npix - 1;
            b.M_READY    = !(lc >= st_lo && lc <= st_hi);
            b.CALC_VALID = idx >= cv_on;
            if (b.M_READY && idx < org) q_start.push_back(idx == 0);
            #1;
            if (!b.M_READY) begin
                checks += 2;
                if (b.S_READY !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: got %0b expected 0", b.S_READY);
                end
                if (b.CALC_ENA !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ena: got %0b expected 0", b.CALC_ENA);
                end
            end
            cycle();
            if (b.M_READY) idx++;
            lc++;
        end
        b.S_VALID    = 1'b0;
        b.S_LAST     = 1'b0;
        b.M_READY    = 1'b1;
        b.CALC_VALID = 1'b1;
        d0 = n_done - 1;
        if (LINE_DONE) d0 = n_done;
        d0 = n_done;
        while (n_done == d0 && w < 20) begin
            cycle();
            w++;
        end
        checks++;
        if (n_done == d0) begin
            errors++;
            $display("FAIL done_timeout: no LINE_DONE within %0d cycles", w);
        end else begin
            checks++;
            if (done_cyc - acc_cyc != 2) begin
                errors++;
                $display("FAIL done_latency: got %0d cycles expected 2", done_cyc - acc_cyc);
            end
        end
        checks += 4;
        if (n_ena - e0 != exp_in) begin
            errors++;
            $display("FAIL ena_count: got %0d expected %0d", n_ena - e0, exp_in);
        end
        if (q_start.size() != 0) begin
            errors++;
            $display("FAIL start_queue: %0d ENA strobes missing", q_start.size());
            q_start.delete();
        end
        if (LINE_DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: LINE_DONE=%0b BUSY=%0b expected 0 0", LINE_DONE, BUSY);
        end
        if (IN_COUNT !== W'(exp_in)) begin
            errors++;
            $display("FAIL in_count_hold: got %0d expected %0d", IN_COUNT, exp_in);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cycle();
        cycle();
        checks += 3;
        if (BUSY !== 1'b0 || LINE_DONE !== 1'b0 || CFG_ERR !== 1'b0 || LEN_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: BUSY=%0b DONE=%0b CFG=%0b LEN=%0b expected 0", BUSY, LINE_DONE, CFG_ERR, LEN_ERR);
        end
        if (IN_COUNT !== '0 || OUT_COUNT !== '0) begin
            errors++;
            $display("FAIL reset_counts: IN=%0d OUT=%0d expected 0 0", IN_COUNT, OUT_COUNT);
        end
        if (b.S_READY !== 1'b0 || b.CALC_ENA !== 1'b0 || b.CALC_START !== 1'b0 || b.OUT_STROBE !== 1'b0) begin
            errors++;
            $display("FAIL reset_stream: RDY=%0b ENA=%0b START=%0b STB=%0b expected 0", b.S_READY, b.CALC_ENA, b.CALC_START, b.OUT_STROBE);
        end
        RST = 1'b0;
        cycle();
    endtask

    task automatic test_nominal();
        send_line(8, 4, 8, -1, -1, 0, 1'b1);
    endtask

    task automatic test_stall();
        send_line(8, 4, 8, 3, 5, 0, 1'b1);
    endtask

    task automatic test_short();
        send_line(8, 4, 5, -1, -1, 0, 1'b1);
    endtask

    task automatic test_long();
        send_line(4, 2, 7, -1, -1, 0, 1'b0);
    endtask

    task automatic test_bad_cfg();
        int c0;
        c0 = n_cfg;
        start_line(4, 5);
        checks += 2;
        if (CFG_ERR !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL cfg_cnv_gt_org: CFG_ERR=%0b BUSY=%0b expected 1 0", CFG_ERR, BUSY);
        end
        cycle();
        if (CFG_ERR !== 1'b0) begin
            errors++;
            $display("FAIL cfg_pulse: CFG_ERR=%0b expected 0", CFG_ERR);
        end
        start_line(0, 1);
        checks += 2;
        if (CFG_ERR !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL cfg_org_zero: CFG_ERR=%0b BUSY=%0b expected 1 0", CFG_ERR, BUSY);
        end
        cycle();
        if (n_cfg - c0 != 2) begin
            errors++;
            $display("FAIL cfg_count: got %0d pulses expected 2", n_cfg - c0);
        end
    endtask

    task automatic test_reset_reentry();
        int d0;
        start_line(8, 4);
        d0 = n_done;
        for (int i = 0; i < 3; i++) begin
            b.S_VALID = 1'b1;
            b.S_LAST  = 1'b0;
            b.M_READY = 1'b1;
            q_start.push_back(i == 0);
            cycle();
        end
        b.S_VALID = 1'b0;
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
        cycle();
        cycle();
        checks += 3;
        if (n_done != d0) begin
            errors++;
            $display("FAIL abort_done: got %0d LINE_DONE pulses expected 0", n_done - d0);
        end
        if (BUSY !== 1'b0 || IN_COUNT !== '0) begin
            errors++;
            $display("FAIL abort_state: BUSY=%0b IN=%0d expected 0 0", BUSY, IN_COUNT);
        end
        if (q_start.size() != 0) begin
            errors++;
            $display("FAIL abort_ena: %0d pre-reset ENA strobes missing", q_start.size());
            q_start.delete();
        end
        send_line(2, 1, 2, -1, -1, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        send_line(3, 3, 3, -1, -1, 0, 1'b1);
        send_line(1, 1, 1, -1, -1, 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        b.S_VALID    = 1'b0;
        b.S_LAST     = 1'b0;
        b.M_READY    = 1'b1;
        b.CALC_VALID = 1'b1;
        test_reset();
        test_nominal();
        test_stall();
        test_short();
        test_long();
        test_bad_cfg();
        test_reset_reentry();
        test_back_to_back();
        checks++;
        if (q_line.size() != 0) begin
            errors++;
            $display("FAIL line_queue: %0d lines never completed", q_line.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aq_reduce_line_ctrl.md
Name: aq_reduce_line_ctrl

Overview:
- Line-level sequencer for the reduce datapath's per-pixel size/weight calculator.
- Accepts one line of input pixels over a valid/ready stream and holds off upstream when the downstream blender stalls.
- Drives the calculator's START/ENA strobes, one ENA per accepted pixel, with START on the first pixel of a line.
- Counts the output pixels the calculator reports and flags configuration and line-length errors.

Parameters:
- W, 16, width of ORG, CNV and both counters.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- LINE_START  in  1  pulse: begin a line, sample ORG/CNV
- ORG  in  W  input pixels per line
- CNV  in  W  output pixels per line
- BUSY  out  1  line in progress (state != IDLE)
- LINE_DONE  out  1  one-cycle pulse, line finished, counts final
- CFG_ERR  out  1  one-cycle pulse, rejected configuration
- LEN_ERR  out  1  sticky per line; cleared on the next accepted LINE_START
- S_VALID  in  1  input pixel valid
- S_READY  out  1  input pixel ready
- S_LAST  in  1  last input pixel of the line
- M_READY  in  1  downstream blender can take a step
- CALC_START  out  1  calculator restart, qualified by CALC_ENA
- CALC_ENA  out  1  calculator advance
- CALC_VALID  in  1  calculator VALID, a level
- OUT_STROBE  out  1  one output pixel produced
- IN_COUNT  out  W  pixels fed to the calculator this line
- OUT_COUNT  out  W  OUT_STROBE count this line

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE; all outputs 0; counters 0; org/cnv latches 0; ena_d1=0.
  - Reset mid-line aborts the line with no LINE_DONE.
  - The next line's CALC_START re-initialises the calculator.
- States: IDLE, RUN, DRAIN, FLUSH, DONE.
- IDLE:
  - S_READY=0.
  - LINE_START=1 with ORG==0, CNV==0 or CNV>ORG: CFG_ERR=1 next cycle, stay IDLE.
  - LINE_START=1 otherwise: latch ORG/CNV, clear IN_COUNT, OUT_COUNT and LEN_ERR, go RUN.
- RUN:
  - S_READY=M_READY, combinational.
  - Accept = S_VALID&&S_READY.
  - Same cycle as each accept: CALC_ENA=1; CALC_START=(IN_COUNT==0); IN_COUNT++ at the edge.
- RUN exit, evaluated on accept:
  - S_LAST=1 and IN_COUNT==org-1: go FLUSH.
  - S_LAST=1 and IN_COUNT<org-1: LEN_ERR=1, go FLUSH (short line).
  - S_LAST=0 and IN_COUNT==org-1: LEN_ERR=1, go DRAIN (long line).
- DRAIN:
  - S_READY=1; pixels are discarded; CALC_ENA=0; IN_COUNT frozen.
  - Accept with S_LAST=1: go FLUSH.
- FLUSH: one cycle; S_READY=0; absorbs the last ena_d1 strobe. Then DONE.
- DONE: LINE_DONE=1 for one cycle; IN_COUNT/OUT_COUNT final and held until the next accepted LINE_START. Then IDLE.
- Output tracking:
  - ena_d1 = CALC_ENA registered.
  - OUT_STROBE = ena_d1 && CALC_VALID, combinational; valid in RUN or FLUSH.
  - OUT_COUNT++ on each OUT_STROBE.
  - The calculator has 1-cycle latency, so the strobe for the last pixel falls in FLUSH.
- Counters saturate at 2^W-1; there is no wrap.
- LINE_START outside IDLE is ignored; no error is raised.
- A LINE_START and a RUN accept in the same cycle are independent; the LINE_START is ignored.
- CALC_START is never asserted without CALC_ENA.

Decomposition:
- Shared package aq_reduce_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/FLUSH/DONE, 3-bit);
  - the default width constant AQ_SIZE_W=16.
- The saturating counter is a natural sub-module, aq_sat_counter (clear, inc, W). It is instantiated twice, for IN_COUNT and OUT_COUNT.
- The FSM stays in the top module.

Test Plan:
- Nominal line:
  - Stimulus: ORG=8, CNV=4; 8 back-to-back pixels with S_LAST on the 8th; CALC_VALID tied 1; M_READY=1.
  - Response: CALC_START only with pixel 0; 8 CALC_ENA; IN_COUNT=8, OUT_COUNT=8; LINE_DONE 2 cycles after the last accept; LEN_ERR=0.
- Stall:
  - Stimulus: same line, M_READY=0 for cycles 3–5.
  - Response: S_READY=0 and CALC_ENA=0 during the stall; counts unchanged at the end (8/8).
- Short line:
  - Stimulus: ORG=8, S_LAST on the 5th pixel.
  - Response: LEN_ERR=1, IN_COUNT=5, LINE_DONE pulses.
- Long line:
  - Stimulus: ORG=4, S_LAST on the 7th pixel.
  - Response: CALC_ENA exactly 4 times; pixels 5–7 accepted and dropped; LEN_ERR=1; IN_COUNT=4.
- Bad config:
  - Stimulus: ORG=4, CNV=5, then ORG=0, CNV=1.
  - Response: a CFG_ERR pulse each time; BUSY stays 0.
- Reset and re-entry:
  - Stimulus: RST asserted mid-line after 3 pixels, then a new line ORG=2, CNV=1.
  - Response: no LINE_DONE for the aborted line; the new line's first ENA carries CALC_START; CALC_VALID pattern 0,1 gives OUT_COUNT=1.
